// File: rtl/led_zone_pkg.sv
// Shared sizes and tx state encoding for the zone gray stream receiver and
// serial LED transmitter.
package led_zone_pkg;
  localparam int ZONE_COLS = 24;
  localparam int ZONE_ROWS = 15;
  localparam int ZONES     = ZONE_COLS * ZONE_ROWS;
  localparam int GRAY_W    = 16;
  localparam int IDX_W     = 9;
  localparam int BIT_W     = $clog2(GRAY_W);

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [GRAY_W-1:0] gray_t;

  typedef enum logic [2:0] {IDLE, RD, LOAD, SHIFT, LATCH} tx_state_t;
endpackage

// File: rtl/zone_gray_tx_if.sv
// Gray stream from the brightness calculator plus LED chain and status lines.
interface zone_gray_tx_if;
  import led_zone_pkg::*;

  logic  new_frame;
  logic  update;
  idx_t  index;
  gray_t gray;
  logic  led_sclk;
  logic  led_sdo;
  logic  led_lat;
  logic  tx_busy;
  logic  frame_err;
  logic  overrun;

  modport master (
    output new_frame, update, index, gray,
    input  led_sclk, led_sdo, led_lat, tx_busy, frame_err, overrun
  );

  modport slave (
    input  new_frame, update, index, gray,
    output led_sclk, led_sdo, led_lat, tx_busy, frame_err, overrun
  );
endinterface

// File: rtl/zone_bank_ram.sv
// Two-bank zone store: one bank is written by the capture side while the
// other is read (registered) by the serializer.
module zone_bank_ram
  import led_zone_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_wr_en,
  input  logic  i_wr_bank,
  input  idx_t  i_wr_idx,
  input  gray_t i_wr_data,
  input  logic  i_rd_bank,
  input  idx_t  i_rd_idx,
  output gray_t o_rd_data
);
  gray_t r_mem [2][ZONES];
  gray_t r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_bank][i_rd_idx];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/zone_gray_tx.sv
// Captures per-zone gray values into a ping-pong buffer and shifts each
// completed frame out MSB first on sclk/sdo, followed by a latch pulse.
module zone_gray_tx
  import led_zone_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int LAT_CYC = 8
) (
  input logic           sys_clk,
  input logic           sys_rst,
  zone_gray_tx_if.slave bus
);
  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LC_W = (LAT_CYC > 1) ? $clog2(LAT_CYC) : 1;

  logic      r_update_d;
  idx_t      r_zone_cnt;
  logic      r_wr_bank;
  logic      r_pending;
  logic      r_err;
  logic      r_ovr;
  tx_state_t r_state;
  idx_t      r_addr;
  logic [BIT_W-1:0] r_bit;
  logic [HC_W-1:0]  r_hcnt;
  logic [LC_W-1:0]  r_lcnt;
  gray_t     r_sr;
  logic      r_sclk;
  logic      r_sdo;
  logic      r_lat;
  logic      r_busy;

  logic  w_stb, w_idx_ok, w_wr, w_complete;
  logic  w_half_end, w_latch_end, w_start, w_restart, w_swap;
  logic  w_rd_bank;
  idx_t  w_rd_idx;
  gray_t w_rd_data;

  // new_frame discards a coincident strobe
  assign w_stb       = bus.update & ~r_update_d & ~bus.new_frame;
  assign w_idx_ok    = bus.index < idx_t'(ZONES);
  assign w_wr        = w_stb & w_idx_ok;
  assign w_complete  = w_wr && (bus.index == idx_t'(ZONES-1)) &&
                       (r_zone_cnt == idx_t'(ZONES-1));
  assign w_half_end  = r_hcnt == HC_W'(CLK_DIV-1);
  assign w_latch_end = (r_state == LATCH) && (r_lcnt == LC_W'(LAT_CYC-1));
  assign w_start     = w_complete && ((r_state == IDLE) || (w_latch_end && !r_pending));
  assign w_restart   = w_latch_end & r_pending;
  assign w_swap      = w_start | w_restart;
  assign w_rd_bank   = ~r_wr_bank;
  // r_addr runs one past the last zone while the final word shifts out
  assign w_rd_idx    = (r_addr < idx_t'(ZONES)) ? r_addr : '0;

  zone_bank_ram u_ram (
    .i_clk     (sys_clk),
    .i_wr_en   (w_wr),
    .i_wr_bank (r_wr_bank),
    .i_wr_idx  (bus.index),
    .i_wr_data (bus.gray),
    .i_rd_bank (w_rd_bank),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_update_d <= 1'b0;
      r_zone_cnt <= '0;
      r_wr_bank  <= 1'b0;
      r_pending  <= 1'b0;
      r_err      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_update_d <= bus.update;
      r_err      <= 1'b0;
      r_ovr      <= 1'b0;
      if (bus.new_frame) begin
        r_zone_cnt <= '0;
        r_err      <= (r_zone_cnt != '0) && (r_zone_cnt != idx_t'(ZONES));
      end else if (w_stb) begin
        if (w_idx_ok) r_zone_cnt <= r_zone_cnt + idx_t'(1);
        else          r_err      <= 1'b1;
      end
      if (w_swap) r_wr_bank <= ~r_wr_bank;
      // a completed frame that cannot start now either queues or is dropped
      if (w_complete && !w_start) begin
        if (r_pending) r_ovr     <= 1'b1;
        else           r_pending <= 1'b1;
      end
      if (w_restart) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_bit   <= '0;
      r_hcnt  <= '0;
      r_lcnt  <= '0;
      r_sr    <= '0;
      r_sclk  <= 1'b0;
      r_sdo   <= 1'b0;
      r_lat   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= RD;
            r_busy  <= 1'b1;
            r_addr  <= '0;
          end
        end
        RD: r_state <= LOAD;
        LOAD: begin
          r_sr    <= w_rd_data;
          r_sdo   <= w_rd_data[GRAY_W-1];
          r_bit   <= BIT_W'(GRAY_W-1);
          r_hcnt  <= '0;
          r_sclk  <= 1'b0;
          r_addr  <= r_addr + idx_t'(1);
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_hcnt <= w_half_end ? '0 : r_hcnt + HC_W'(1);
          if (w_half_end) begin
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              if (r_bit != '0) begin
                r_bit <= r_bit - BIT_W'(1);
                r_sr  <= {r_sr[GRAY_W-2:0], 1'b0};
                r_sdo <= r_sr[GRAY_W-2];
              end else if (r_addr == idx_t'(ZONES)) begin
                r_state <= LATCH;
                r_lat   <= 1'b1;
                r_sdo   <= 1'b0;
                r_lcnt  <= '0;
              end else begin
                // next word was already read while this one shifted
                r_sr   <= w_rd_data;
                r_sdo  <= w_rd_data[GRAY_W-1];
                r_bit  <= BIT_W'(GRAY_W-1);
                r_addr <= r_addr + idx_t'(1);
              end
            end
          end
        end
        LATCH: begin
          r_lcnt <= r_lcnt + LC_W'(1);
          if (w_latch_end) begin
            r_lat <= 1'b0;
            if (w_swap) begin
              r_state <= RD;
              r_addr  <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.led_sclk  = r_sclk;
  assign bus.led_sdo   = r_sdo;
  assign bus.led_lat   = r_lat;
  assign bus.tx_busy   = r_busy;
  assign bus.frame_err = r_err;
  assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_zone_gray_tx.sv
// Directed bench for zone_gray_tx: capture-side vector table plus full-frame,
// back-to-back, and mid-transfer reset sequences decoded off sclk/sdo.
module tb_zone_gray_tx;
  import led_zone_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  zone_gray_tx_if bus();

  zone_gray_tx #(.CLK_DIV(1), .LAT_CYC(8)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // chain monitor: monotonic counters, tests work with deltas
  int   rise_cnt = 0, lat_cnt = 0, err_cnt = 0, ovr_cnt = 0, busy_cnt = 0;
  int   w_total = 0, bitn = 0;
  logic prev_sclk = 1'b0;
  logic [15:0] acc = '0;
  logic [15:0] words [4096];

  always @(negedge sys_clk) begin
    if (!prev_sclk && bus.led_sclk) begin
      rise_cnt++;
      acc = {acc[14:0], bus.led_sdo};
      bitn++;
      if (bitn == 16) begin
        words[w_total % 4096] = acc;
        w_total++;
        bitn = 0;
      end
    end
    prev_sclk = bus.led_sclk;
    lat_cnt  += int'(bus.led_lat);
    err_cnt  += int'(bus.frame_err);
    ovr_cnt  += int'(bus.overrun);
    busy_cnt += int'(bus.tx_busy);
    if (sys_rst) bitn = 0;
  end

  typedef struct {
    logic        nf;
    logic        upd;
    logic [8:0]  idx;
    logic [15:0] g;
    logic        exp_err;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t vt [28];

  function automatic vec_t mk(logic nf, logic upd, logic [8:0] idx, logic [15:0] g,
                              logic e, logic [8:0] c);
    vec_t v;
    v.nf = nf; v.upd = upd; v.idx = idx; v.g = g; v.exp_err = e; v.exp_cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  function automatic logic [15:0] gray_of(input int pat, input int i);
    case (pat)
      0:       return 16'(i * 16'h00B7);
      1:       return 16'(i) ^ 16'h5A00;
      default: return ~16'(i * 3);
    endcase
  endfunction

  task automatic send_zone(input int idx, input logic [15:0] g);
    bus.index  = idx[8:0];
    bus.gray   = g;
    bus.update = 1'b1;
    tick(); tick(); tick();
    bus.update = 1'b0;
    tick();
  endtask

  task automatic pulse_nf();
    bus.new_frame = 1'b1;
    tick();
    bus.new_frame = 1'b0;
    tick();
  endtask

  task automatic send_frame(input int pat);
    pulse_nf();
    for (int i = 0; i < ZONES; i++) send_zone(i, gray_of(pat, i));
  endtask

  task automatic wait_lat(input string name, input int budget);
    int n = 0;
    while (!bus.led_lat && n < budget) begin tick(); n++; end
    check(name, int'(bus.led_lat), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.tx_busy && n < budget) begin tick(); n++; end
    check(name, int'(bus.tx_busy), 0);
  endtask

  task automatic cmp_frame(input string name, input int w0, input int pat);
    int bad = 0;
    for (int k = 0; k < ZONES; k++)
      if (words[(w0 + k) % 4096] !== gray_of(pat, k)) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    int r0, w0, e0, o0, b0, n;

    for (int i = 0; i < 11; i++) vt[i] = mk(0, 1, 9'd5, 16'hA5C3, 0, 9'd1);
    vt[11] = mk(0, 0, 9'd5,   16'h0000, 0, 9'd1);
    vt[12] = mk(0, 1, 9'd400, 16'h1111, 1, 9'd1);
    vt[13] = mk(0, 1, 9'd400, 16'h1111, 0, 9'd1);
    vt[14] = mk(0, 0, 9'd0,   16'h0000, 0, 9'd1);
    vt[15] = mk(0, 1, 9'd6,   16'h2222, 0, 9'd2);
    vt[16] = mk(1, 0, 9'd0,   16'h0000, 1, 9'd0);
    vt[17] = mk(0, 0, 9'd0,   16'h0000, 0, 9'd0);
    vt[18] = mk(1, 0, 9'd0,   16'h0000, 0, 9'd0);
    vt[19] = mk(1, 1, 9'd7,   16'h3333, 0, 9'd0);
    vt[20] = mk(0, 1, 9'd7,   16'h3333, 0, 9'd0);
    vt[21] = mk(0, 0, 9'd0,   16'h0000, 0, 9'd0);
    vt[22] = mk(0, 1, 9'd360, 16'h4444, 1, 9'd0);
    vt[23] = mk(0, 0, 9'd0,   16'h0000, 0, 9'd0);
    vt[24] = mk(0, 1, 9'd359, 16'h5555, 0, 9'd1);
    vt[25] = mk(0, 0, 9'd0,   16'h0000, 0, 9'd1);
    vt[26] = mk(1, 0, 9'd0,   16'h0000, 1, 9'd0);
    vt[27] = mk(0, 0, 9'd0,   16'h0000, 0, 9'd0);

    bus.new_frame = 1'b0;
    bus.update    = 1'b0;
    bus.index     = '0;
    bus.gray      = '0;
    tick(); tick();
    check("reset_outputs", int'({bus.led_sclk, bus.led_sdo, bus.led_lat,
                                 bus.tx_busy, bus.frame_err, bus.overrun}), 0);
    sys_rst = 1'b0;
    tick();
    check("reset_state", int'(dut.r_state), int'(IDLE));
    check("reset_cnt_bank", int'({dut.r_zone_cnt, dut.r_wr_bank, dut.r_pending}), 0);

    // capture-side vector table
    foreach (vt[i]) begin
      bus.new_frame = vt[i].nf;
      bus.update    = vt[i].upd;
      bus.index     = vt[i].idx;
      bus.gray      = vt[i].g;
      tick();
      check($sformatf("vec%0d_err", i), int'(bus.frame_err), int'(vt[i].exp_err));
      check($sformatf("vec%0d_cnt", i), int'(dut.r_zone_cnt), int'(vt[i].exp_cnt));
    end
    bus.new_frame = 1'b0;
    bus.update    = 1'b0;
    check("vec_no_tx", int'(bus.tx_busy), 0);

    // single full frame, index*0xB7
    r0 = rise_cnt; w0 = w_total; e0 = err_cnt; b0 = busy_cnt;
    send_frame(0);
    check("f0_busy_start", int'(bus.tx_busy), 1);
    wait_lat("f0_lat_seen", 20000);
    n = 0;
    while (bus.led_lat && n < 100) begin tick(); n++; end
    check("f0_lat_len", n, 8);
    check("f0_busy_after_lat", int'(bus.tx_busy), 0);
    check("f0_rises", rise_cnt - r0, ZONES * GRAY_W);
    check("f0_words", w_total - w0, ZONES);
    check("f0_busy_cycles", busy_cnt - b0, ZONES * GRAY_W * 2 + 8 + 2);
    check("f0_err", err_cnt - e0, 0);
    check("f0_word1", int'(words[(w0 + 1) % 4096]), 16'h00B7);
    cmp_frame("f0_data", w0, 0);

    // incomplete frame of 100 zones
    pulse_nf();
    for (int i = 0; i < 100; i++) send_zone(i, 16'(i));
    check("p100_cnt", int'(dut.r_zone_cnt), 100);
    bus.new_frame = 1'b1;
    tick();
    bus.new_frame = 1'b0;
    check("p100_err_pulse", int'(bus.frame_err), 1);
    check("p100_cnt_clr", int'(dut.r_zone_cnt), 0);
    tick();
    check("p100_err_single", int'(bus.frame_err), 0);

    // three complete frames while the first transmits
    r0 = rise_cnt; w0 = w_total; e0 = err_cnt; o0 = ovr_cnt; b0 = busy_cnt;
    send_frame(0);
    check("bb_busy", int'(bus.tx_busy), 1);
    send_frame(1);
    check("bb_pending", int'(dut.r_pending), 1);
    check("bb_ovr_after2", ovr_cnt - o0, 0);
    send_frame(2);
    check("bb_ovr_after3", ovr_cnt - o0, 1);
    check("bb_still_busy", int'(bus.tx_busy), 1);
    wait_idle("bb_idle", 30000);
    check("bb_rises", rise_cnt - r0, 2 * ZONES * GRAY_W);
    check("bb_busy_cycles", busy_cnt - b0, 2 * (ZONES * GRAY_W * 2 + 8 + 2));
    check("bb_err", err_cnt - e0, 0);
    check("bb_pending_clr", int'(dut.r_pending), 0);
    cmp_frame("bb_data1", w0, 0);
    cmp_frame("bb_data2", w0 + ZONES, 2);

    // reset during word 200
    w0 = w_total;
    send_frame(1);
    n = 0;
    while (w_total - w0 < 200 && n < 20000) begin tick(); n++; end
    check("rst_reach_w200", w_total - w0, 200);
    tick(); tick(); tick(); tick(); tick();
    sys_rst = 1'b1;
    tick();
    check("rst_mid_outputs", int'({bus.led_sclk, bus.led_sdo, bus.led_lat,
                                   bus.tx_busy, bus.frame_err, bus.overrun}), 0);
    check("rst_mid_state", int'(dut.r_state), int'(IDLE));
    sys_rst = 1'b0;
    tick();
    r0 = rise_cnt; w0 = w_total; e0 = err_cnt;
    send_frame(2);
    wait_lat("rc_lat_seen", 20000);
    wait_idle("rc_idle", 100);
    check("rc_rises", rise_cnt - r0, ZONES * GRAY_W);
    check("rc_err", err_cnt - e0, 0);
    cmp_frame("rc_data", w0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
